// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and status flag layout.
// Flags are packed {V,N,Z,C}, so FLAG_C is bit 0 and FLAG_V is bit 3.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU producing a result and {V,N,Z,C} flags.
// Optional ALU_PIPE_SAT_EN: ADD/SUB clamp to the signed range on overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           sel,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign op = alu_op_e'(sel);

  // Extra top bit holds the carry (ADD) or the borrow (SUB).
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  assign add_ovf = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow the true result has the sign of a, so a picks the clamp rail.
  logic [WIDTH-1:0] sat_val;
  assign sat_val = a[MSB] ? SMIN : SMAX;
  assign add_res = add_ovf ? sat_val : sum_ext[WIDTH-1:0];
  assign sub_res = sub_ovf ? sat_val : diff_ext[WIDTH-1:0];
`else
  assign add_res = sum_ext[WIDTH-1:0];
  assign sub_res = diff_ext[WIDTH-1:0];
`endif

  always_comb begin
    res   = a;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        res   = add_res;
        carry = sum_ext[WIDTH];
        ovf   = add_ovf;
      end
      OP_SUB: begin
        res   = sub_res;
        carry = diff_ext[WIDTH];
        ovf   = sub_ovf;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        carry = a[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      OP_PASS: res = a;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[MSB];
    flags[FLAG_V] = ovf;
  end

  assign result = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides; wraps alu_core.
// Build option ALU_PIPE_SAT_EN (handled in alu_core) enables signed saturation.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

  // Handshake: a beat transfers on a rising edge where valid && ready. Valid
  // never depends on ready; in_ready depends only on pipeline state and
  // out_ready, never on in_valid. Outputs hold while out_valid && !out_ready.

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [2:0]           s1_sel;
  logic                 adv1;
  logic                 adv2;
  logic                 in_fire;
  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign in_fire  = in_valid && in_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .sel    (s1_sel),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sel    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_a   <= a;
          s1_b   <= b;
          s1_sel <= sel;
        end
      end
      // Only valid beats overwrite the output registers, so bubbles leave them quiet.
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result <= core_result;
          flags  <= core_flags;
        end
      end
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 4-bit combinational ALU.
- Same 3-bit opcode set, generalised to WIDTH bits.
- Adds registered status flags (C/Z/N/V) and valid/ready handshakes on input and output.
- Sits between operand issue logic and the writeback path; tolerates downstream backpressure at full throughput.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  3  opcode.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {V,N,Z,C}; bit3=V, bit0=C.

Behaviour:
- Opcodes:
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL a<<1
  - 110 SHR a>>1 (logical)
  - 111 PASS a
- Arithmetic is modulo 2^WIDTH; the carry-out is captured separately in C.
- Flags:
  - C, ADD: carry out of the MSB.
  - C, SUB: borrow (1 when a<b unsigned).
  - C, SHL: shifted-out a[WIDTH-1].
  - C, SHR: shifted-out a[0].
  - C, logic ops and PASS: 0.
  - Z: result==0.
  - N: result[WIDTH-1].
  - V, ADD/SUB: signed overflow. V, all other ops: 0.
- Stage S1: registers a, b, sel and s1_valid.
- Stage S2: registers result, flags and out_valid, computed from the S1 registers.
- Latency: 2 cycles from input handshake to out_valid when not stalled; throughput of 1 beat per cycle.
- Advance rules:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational; no dependence on in_valid).
- Input handshake: fires when in_valid && in_ready. S1 loads and s1_valid <= 1.
- When adv1 holds and no input beat arrives, s1_valid <= 0.
- When adv2 holds, S2 loads the S1 contents and out_valid <= s1_valid.
- Output hold: while out_valid && !out_ready, result, flags and out_valid hold stable.
- Full stall: with S1 and S2 both full, in_ready=0 and no beat is lost or duplicated.
- Simultaneous events: an output handshake and an input handshake in the same cycle are both honoured; the pipeline shifts by one.
- Reset values: s1_valid=0, out_valid=0, result=0, flags=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are dropped with no partial outputs. rst has priority over every handshake.
- Invalid opcodes: none, since all 8 encodings are defined.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - ADD/SUB saturate to the signed range: max 2^(WIDTH-1)-1, min -2^(WIDTH-1) on overflow.
  - V still reports that overflow occurred.
  - C is computed from the unsaturated operation.
  - Z and N reflect the saturated result.
- Undefined: wrap-around arithmetic as above, with no saturation logic synthesised.

Decomposition:
- Package alu_pkg holds:
  - Opcode enum: OP_ADD..OP_PASS with the encodings above.
  - Flag index constants: FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
  - Flag width constant: NUM_FLAGS=4.
- Sub-module alu_core: purely combinational (a, b, sel -> result, flags), parametrised by WIDTH. It contains the ALU_PIPE_SAT_EN logic.
- alu_pipe holds only the pipeline registers and handshake logic.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> 2 cycles later result=0x10, C=1, Z=0, N=0, V=0.
- SUB a=0x80 b=0x01 -> result=0x7F, C=0, V=1, N=0.
  - With ALU_PIPE_SAT_EN: result=0x80, V=1, N=1.
- Back-to-back: 6 beats on consecutive cycles with out_ready=1 -> 6 results on consecutive cycles, in order, in_ready held 1.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> in_ready drops after S1 and S2 fill, result held stable; release -> all beats delivered once, in order.
- Shifts: SHL a=0x81 -> 0x02, C=1. SHR a=0x01 -> 0x00, C=1, Z=1.
- Reset mid-stream: assert rst with 2 beats in flight -> next cycle out_valid=0, result=0, flags=0, in_ready=1; no stale beat emerges afterwards.
